// File: rtl/llfifo_drain_reader_pkg.sv
// rtl/llfifo_drain_reader_pkg.sv - shared types and defaults for the linked-list FIFO read side.
package llfifo_drain_reader_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_DEPTH     = 2;
  localparam int DEF_NUM_FIFOS = 2;
  localparam int BUF_DEPTH     = 2;

  // Next queue index with explicit wrap, so non-power-of-2 queue counts never escape the range.
  function automatic int unsigned wrap_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/llfifo_rr_arbiter.sv
// rtl/llfifo_rr_arbiter.sv - combinational round-robin pick: first request after rr_ptr.
import llfifo_drain_reader_pkg::*;

module llfifo_rr_arbiter #(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [SEL_WIDTH-1:0] rr_ptr,
  output logic                 gnt_vld,
  output logic [SEL_WIDTH-1:0] gnt_idx
);

  always_comb begin
    int unsigned            idx;
    logic [SEL_WIDTH-1:0]   sel;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 32'(rr_ptr);
    sel     = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      idx = wrap_next(idx, NUM_FIFOS);
      sel = SEL_WIDTH'(idx);
      if (!gnt_vld && req[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end
  end

endmodule

// File: rtl/llfifo_drain_reader.sv
// rtl/llfifo_drain_reader.sv - round-robin pop engine with a 2-entry output buffer and a drain FSM.
import llfifo_drain_reader_pkg::*;

module llfifo_drain_reader #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     data_out,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  input  logic [NUM_FIFOS-1:0] en_mask,
  input  logic                 drain_req,
  input  logic [SEL_WIDTH-1:0] drain_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_qid,
  output logic                 drain_busy,
  output logic                 drain_done
);

  if (NUM_FIFOS < 2 || DEPTH < 1) begin : g_bad_params
    $error("llfifo_drain_reader: NUM_FIFOS must be >= 2 and DEPTH >= 1");
  end

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] dq_q, dq_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [WIDTH-1:0]     buf_data_q [BUF_DEPTH];
  logic [SEL_WIDTH-1:0] buf_qid_q  [BUF_DEPTH];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           count_q;

  logic [NUM_FIFOS-1:0] req;
  logic [NUM_FIFOS-1:0] dq_onehot;
  logic                 gnt_vld;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic                 deq;
  logic                 space;
  logic                 dq_empty;

  llfifo_rr_arbiter #(
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // An out-of-range drain queue decodes to no bits, so it reads as empty and finishes at once.
  always_comb begin
    dq_onehot = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      dq_onehot[i] = (dq_q == SEL_WIDTH'(i));
    end
  end

  assign dq_empty = ~|(dq_onehot & ~empty);

  always_comb begin
    req = '0;
    case (state_q)
      ST_RUN:   req = ~empty & en_mask;
      ST_DRAIN: req = dq_onehot & ~empty;
      default:  req = '0;
    endcase
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_qid   = buf_qid_q[rd_ptr_q];
  assign deq       = out_valid & out_ready;
  // Counting the entry leaving this cycle keeps full throughput when the buffer is full.
  assign space     = (count_q - {1'b0, deq}) < 2'd2;

  assign pop     = gnt_vld & space & ~rst;
  assign pop_sel = rst ? '0 : gnt_idx;

  assign drain_busy = (state_q == ST_DRAIN);
  assign drain_done = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    dq_d     = dq_q;
    rr_ptr_d = pop ? gnt_idx : rr_ptr_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
          dq_d    = drain_sel;
        end
      end
      ST_DRAIN: begin
        if (dq_empty) state_d = ST_DONE;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      dq_q     <= '0;
      rr_ptr_q <= SEL_WIDTH'(NUM_FIFOS - 1);
    end else begin
      state_q  <= state_d;
      dq_q     <= dq_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_qid_q[i]  <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (pop) begin
        buf_data_q[wr_ptr_q] <= data_out;
        buf_qid_q[wr_ptr_q]  <= pop_sel;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, pop} - {1'b0, deq};
    end
  end

endmodule
